// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues 16-bit instruction words to the ALU.
// Flow per instruction: accept -> read regfile -> execute/writeback, with PSR flag capture.
// Optional build macro: ALU_ISSUE_BACK2BACK_EN lets a new instruction be accepted while
// the current one executes, giving one instruction every two cycles.
module alu_issue_ctrl #(
  parameter int unsigned BIT_WIDTH    = 16,
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned FLAG_WIDTH   = 5,
  parameter int unsigned REG_ADDR_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  input  logic [15:0]             instr,
  output logic                    instr_ready,
  output logic [REG_ADDR_W-1:0]   rf_ra_addr,
  output logic [REG_ADDR_W-1:0]   rf_rb_addr,
  input  logic [BIT_WIDTH-1:0]    rf_ra_data,
  input  logic [BIT_WIDTH-1:0]    rf_rb_data,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_wa,
  output logic [BIT_WIDTH-1:0]    rf_wd,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [BIT_WIDTH-1:0]    alu_rdest,
  output logic [BIT_WIDTH-1:0]    alu_rsrc_imm,
  input  logic [BIT_WIDTH-1:0]    alu_result,
  input  logic [FLAG_WIDTH-1:0]   alu_flags,
  output logic [FLAG_WIDTH-1:0]   psr,
  output logic                    done,
  output logic                    illegal
);

  // Flag order {C,L,F,Z,N}
  localparam logic [4:0] MASK_ARITH = 5'b10111;
  localparam logic [4:0] MASK_ADDU  = 5'b11010;
  localparam logic [4:0] MASK_CMP   = 5'b01011;
  localparam logic [4:0] MASK_LOGIC = 5'b00010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t                  state;
  logic [15:0]             ir;
  logic                    rf_we_q;
  logic                    done_q;
  logic                    illegal_q;
  logic                    use_reg_q;
  logic [BIT_WIDTH-1:0]    imm_q;
  logic [FLAG_WIDTH-1:0]   mask_q;

  logic [3:0]              op;
  logic [3:0]              ext;
  logic                    accept;

  logic                    dec_legal;
  logic                    dec_use_reg;
  logic                    dec_wb;
  logic [FLAG_WIDTH-1:0]   dec_mask;
  logic [BIT_WIDTH-1:0]    dec_imm;

  assign op  = ir[15:12];
  assign ext = ir[7:4];

  // Ready only while rst_n is high; in EXEC only when back-to-back issue is built in
`ifdef ALU_ISSUE_BACK2BACK_EN
  assign instr_ready = rst_n && ((state == IDLE) || (state == EXEC));
`else
  assign instr_ready = rst_n && (state == IDLE);
`endif
  assign accept = instr_valid && instr_ready;

  // Decode the latched instruction: legality, operand B source, writeback, PSR mask
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_reg = 1'b0;
    dec_wb      = 1'b0;
    dec_mask    = '0;
    dec_imm     = '0;
    case (op)
      4'h0: begin
        case (ext)
          4'h0: dec_legal = 1'b1;
          4'h1, 4'h2, 4'h3, 4'h4: begin
            dec_legal = 1'b1; dec_use_reg = 1'b1; dec_wb = 1'b1;
            dec_mask  = FLAG_WIDTH'(MASK_LOGIC);
          end
          4'h5, 4'h7, 4'h9: begin
            dec_legal = 1'b1; dec_use_reg = 1'b1; dec_wb = 1'b1;
            dec_mask  = FLAG_WIDTH'(MASK_ARITH);
          end
          4'h6: begin
            dec_legal = 1'b1; dec_use_reg = 1'b1; dec_wb = 1'b1;
            dec_mask  = FLAG_WIDTH'(MASK_ADDU);
          end
          4'hB: begin
            dec_legal = 1'b1; dec_use_reg = 1'b1;
            dec_mask  = FLAG_WIDTH'(MASK_CMP);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      4'h5, 4'h7, 4'h9: begin
        dec_legal = 1'b1; dec_wb = 1'b1;
        dec_imm   = BIT_WIDTH'($signed(ir[7:0]));
        dec_mask  = FLAG_WIDTH'(MASK_ARITH);
      end
      4'h6: begin
        dec_legal = 1'b1; dec_wb = 1'b1;
        dec_imm   = BIT_WIDTH'(ir[7:0]);
        dec_mask  = FLAG_WIDTH'(MASK_ADDU);
      end
      4'hB: begin
        dec_legal = 1'b1;
        dec_imm   = BIT_WIDTH'($signed(ir[7:0]));
        dec_mask  = FLAG_WIDTH'(MASK_CMP);
      end
      4'h8: begin
        if ((ext == 4'h4) || (ext == 4'h6)) begin
          dec_legal = 1'b1; dec_use_reg = 1'b1; dec_wb = 1'b1;
          dec_mask  = FLAG_WIDTH'(MASK_LOGIC);
        end else if ((ext[3:1] == 3'b000) || (ext[3:1] == 3'b001) ||
                     (ext[3:1] == 3'b100) || (ext[3:1] == 3'b101)) begin
          dec_legal = 1'b1; dec_wb = 1'b1;
          dec_imm   = BIT_WIDTH'($signed({ext[0], ir[3:0]}));
          dec_mask  = FLAG_WIDTH'(MASK_LOGIC);
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Issue FSM with registered EXEC-cycle controls and PSR capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ir         <= '0;
      psr        <= '0;
      rf_we_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      use_reg_q  <= 1'b0;
      imm_q      <= '0;
      mask_q     <= '0;
      alu_opcode <= '0;
    end else begin
      rf_we_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      alu_opcode <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            ir    <= instr;
            state <= READ;
          end
        end
        READ: begin
          state      <= EXEC;
          alu_opcode <= dec_legal ? OPCODE_WIDTH'({op, ext}) : '0;
          rf_we_q    <= dec_legal && dec_wb;
          done_q     <= 1'b1;
          illegal_q  <= !dec_legal;
          use_reg_q  <= dec_use_reg;
          imm_q      <= dec_imm;
          mask_q     <= dec_legal ? dec_mask : '0;
        end
        EXEC: begin
          psr <= (psr & ~mask_q) | (alu_flags & mask_q);
          if (accept) begin
            ir    <= instr;
            state <= READ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing in EXEC must suppress the write and the retire pulses
  assign rf_we   = rf_we_q && rst_n;
  assign done    = done_q && rst_n;
  assign illegal = illegal_q && rst_n;

  // Regfile addressing comes straight from the latched instruction fields
  assign rf_ra_addr = REG_ADDR_W'(ir[11:8]);
  assign rf_rb_addr = REG_ADDR_W'(ir[3:0]);
  assign rf_wa      = REG_ADDR_W'(ir[11:8]);
  assign rf_wd      = alu_result;

  // Operands only carry data during EXEC (sync-read data arrives then)
  assign alu_rdest    = (state == EXEC) ? rf_ra_data : '0;
  assign alu_rsrc_imm = (state == EXEC) ? (use_reg_q ? rf_rb_data : imm_q) : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a regfile and ALU model around alu_issue_ctrl.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_BACK2BACK_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_ra_addr, rf_rb_addr, rf_wa;
  logic [15:0] rf_ra_data, rf_rb_data, rf_wd;
  logic        rf_we;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_rdest, alu_rsrc_imm, alu_result;
  logic [4:0]  alu_flags, psr;
  logic        done, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .rf_ra_addr   (rf_ra_addr),
    .rf_rb_addr   (rf_rb_addr),
    .rf_ra_data   (rf_ra_data),
    .rf_rb_data   (rf_rb_data),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .alu_opcode   (alu_opcode),
    .alu_rdest    (alu_rdest),
    .alu_rsrc_imm (alu_rsrc_imm),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .psr          (psr),
    .done         (done),
    .illegal      (illegal)
  );

  // Register file: synchronous read, write on clock edge, bench preload port
  logic [15:0] regs [16];
  logic        tb_we;
  logic [3:0]  tb_wa;
  logic [15:0] tb_wd;

  always @(posedge clk) begin
    if (tb_we) regs[tb_wa] <= tb_wd;
    else if (rf_we) regs[rf_wa] <= rf_wd;
    rf_ra_data <= regs[rf_ra_addr];
    rf_rb_data <= regs[rf_rb_addr];
  end

  // ALU model; flags the op does not define are driven to 1 so any leak into psr shows
  logic [3:0]  a_op, a_ex;
  logic [16:0] sum;
  logic [4:0]  sh;
  always_comb begin
    a_op       = alu_opcode[7:4];
    a_ex       = alu_opcode[3:0];
    sum        = '0;
    sh         = '0;
    alu_result = '0;
    alu_flags  = '1;
    if ((a_op == 4'h0 && (a_ex == 4'h5 || a_ex == 4'h7)) || a_op == 4'h5 || a_op == 4'h7) begin
      sum = {1'b0, alu_rdest} + {1'b0, alu_rsrc_imm} +
            17'(((a_op == 4'h0 && a_ex == 4'h7) || a_op == 4'h7) ? psr[4] : 1'b0);
      alu_result   = sum[15:0];
      alu_flags[4] = sum[16];
      alu_flags[2] = (alu_rdest[15] == alu_rsrc_imm[15]) && (alu_result[15] != alu_rdest[15]);
      alu_flags[1] = (alu_result == 16'h0);
      alu_flags[0] = alu_result[15];
    end else if ((a_op == 4'h0 && a_ex == 4'h6) || a_op == 4'h6) begin
      sum = {1'b0, alu_rdest} + {1'b0, alu_rsrc_imm};
      alu_result   = sum[15:0];
      alu_flags[4] = sum[16];
      alu_flags[3] = 1'b0;
      alu_flags[1] = (alu_result == 16'h0);
    end else if ((a_op == 4'h0 && a_ex == 4'h9) || a_op == 4'h9) begin
      sum = {1'b0, alu_rdest} - {1'b0, alu_rsrc_imm};
      alu_result   = sum[15:0];
      alu_flags[4] = sum[16];
      alu_flags[2] = (alu_rdest[15] != alu_rsrc_imm[15]) && (alu_result[15] != alu_rdest[15]);
      alu_flags[1] = (alu_result == 16'h0);
      alu_flags[0] = alu_result[15];
    end else if ((a_op == 4'h0 && a_ex == 4'hB) || a_op == 4'hB) begin
      alu_flags[3] = alu_rsrc_imm > alu_rdest;
      alu_flags[1] = alu_rsrc_imm == alu_rdest;
      alu_flags[0] = $signed(alu_rsrc_imm) > $signed(alu_rdest);
    end else if (a_op == 4'h0 && a_ex >= 4'h1 && a_ex <= 4'h4) begin
      case (a_ex)
        4'h1:    alu_result = alu_rdest & alu_rsrc_imm;
        4'h2:    alu_result = alu_rdest | alu_rsrc_imm;
        4'h3:    alu_result = alu_rdest ^ alu_rsrc_imm;
        default: alu_result = ~alu_rsrc_imm;
      endcase
      alu_flags[1] = (alu_result == 16'h0);
    end else if (a_op == 4'h8) begin
      if (!alu_rsrc_imm[4]) begin
        alu_result = alu_rdest << alu_rsrc_imm[3:0];
      end else begin
        sh = 5'(~alu_rsrc_imm[4:0] + 5'd1);
        alu_result = alu_rdest >> sh;
      end
      alu_flags[1] = (alu_result == 16'h0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Handshake one instruction; returns at the falling edge of the READ cycle
  task automatic send(input logic [15:0] ins);
    int waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] ins, input logic [7:0] exp_opc, input logic exp_we,
                     input logic exp_ill, input logic chk_ops,
                     input logic [15:0] exp_a, input logic [15:0] exp_b);
    logic [3:0] f_rd, f_rs;
    f_rd = ins[11:8];
    f_rs = ins[3:0];
    send(ins);
    check("read_ready", 32'(instr_ready), 32'd0);
    check("read_ra_addr", 32'(rf_ra_addr), 32'(f_rd));
    check("read_rb_addr", 32'(rf_rb_addr), 32'(f_rs));
    check("read_done", 32'(done), 32'd0);
    check("read_opcode", 32'(alu_opcode), 32'd0);
    check("read_rdest", 32'(alu_rdest), 32'd0);
    @(negedge clk);
    check("exec_done", 32'(done), 32'd1);
    check("exec_we", 32'(rf_we), 32'(exp_we));
    check("exec_illegal", 32'(illegal), 32'(exp_ill));
    check("exec_opcode", 32'(alu_opcode), 32'(exp_opc));
    check("exec_ready", 32'(instr_ready), 32'(B2B));
    if (chk_ops) begin
      check("exec_rdest", 32'(alu_rdest), 32'(exp_a));
      check("exec_rsrc_imm", 32'(alu_rsrc_imm), 32'(exp_b));
    end
    if (exp_we) check("exec_wa", 32'(rf_wa), 32'(f_rd));
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_we", 32'(rf_we), 32'd0);
    check("post_opcode", 32'(alu_opcode), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_psr", 32'(psr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_rdest", 32'(alu_rdest), 32'd0);
    check("rst_rsrc_imm", 32'(alu_rsrc_imm), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(instr_ready), 32'd1);

    set_reg(4'd1, 16'h0003); set_reg(4'd2, 16'h0004); set_reg(4'd3, 16'h7FFF);
    set_reg(4'd4, 16'h0005); set_reg(4'd5, 16'h0005); set_reg(4'd6, 16'h0001);

    // ADD r1,r2
    run(16'h0152, 8'h05, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0004);
    check("add_r1", 32'(regs[1]), 32'h0007);
    check("add_psr", 32'(psr), 32'h00);
    // ADDI r3,#1: signed overflow
    run(16'h5301, 8'h50, 1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h0001);
    check("addi_r3", 32'(regs[3]), 32'h8000);
    check("addi_psr", 32'(psr), 32'h05);
    // ADDUI r3,#0xFF: zero-extended immediate
    run(16'h63FF, 8'h6F, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h00FF);
    check("addui_r3", 32'(regs[3]), 32'h80FF);
    check("addui_psr", 32'(psr), 32'h05);
    // ADDI r3,#-1: sign-extended immediate, carry out
    run(16'h53FF, 8'h5F, 1'b1, 1'b0, 1'b1, 16'h80FF, 16'hFFFF);
    check("addim1_r3", 32'(regs[3]), 32'h80FE);
    check("addim1_psr", 32'(psr), 32'h11);
    // CMP r4,r5: no writeback, Z set
    run(16'h04B5, 8'h0B, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005);
    check("cmp_r4", 32'(regs[4]), 32'h0005);
    check("cmp_psr", 32'(psr), 32'h12);
    // LSHI r6,#4 then LSHI r6,#-4
    run(16'h8604, 8'h80, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0004);
    check("lshl_r6", 32'(regs[6]), 32'h0010);
    check("lshl_psr", 32'(psr), 32'h10);
    run(16'h861C, 8'h81, 1'b1, 1'b0, 1'b1, 16'h0010, 16'hFFFC);
    check("lshr_r6", 32'(regs[6]), 32'h0001);
    check("lshr_psr", 32'(psr), 32'h10);
    // Undefined R-type extension: retires as no-op
    run(16'h01D2, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("ill_r1", 32'(regs[1]), 32'h0007);
    check("ill_psr", 32'(psr), 32'h10);

    // Reset during READ aborts the instruction
    send(16'h0152);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_we", 32'(rf_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready_low", 32'(instr_ready), 32'd0);
    check("abort_psr", 32'(psr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_done2", 32'(done), 32'd0);
    check("abort_r1", 32'(regs[1]), 32'h0007);

`ifdef ALU_ISSUE_BACK2BACK_EN
    // ADD r1,r2 then ADD r1,r1 issued back to back
    set_reg(4'd1, 16'h0003); set_reg(4'd2, 16'h0004);
    send(16'h0152);
    @(negedge clk);
    check("b2b_exec1_done", 32'(done), 32'd1);
    check("b2b_exec1_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = 16'h0151;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_read2_done", 32'(done), 32'd0);
    check("b2b_r1_mid", 32'(regs[1]), 32'h0007);
    @(negedge clk);
    check("b2b_exec2_done", 32'(done), 32'd1);
    check("b2b_exec2_rdest", 32'(alu_rdest), 32'h0007);
    check("b2b_exec2_rsrc", 32'(alu_rsrc_imm), 32'h0007);
    @(negedge clk);
    check("b2b_r1", 32'(regs[1]), 32'h000E);
    check("b2b_psr", 32'(psr), 32'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
